// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - datapath-facing signal bundle of the multicycle MIPS controller
interface mips_multicycle_control_if #(
  parameter int ALU_CNTRL_W = 4,
  parameter int CNT_W       = 16
);
  logic [5:0]             op_in;
  logic [5:0]             func_in;
  logic                   zero_in;
  logic                   mem_ready_in;
  logic                   pcWrite_out;
  logic                   irWrite_out;
  logic                   memRead_out;
  logic                   memWrite_out;
  logic                   iOrD_out;
  logic                   regWrite_out;
  logic                   regDst_out;
  logic                   memToReg_out;
  logic                   ALUSrcA_out;
  logic                   extCntrl_out;
  logic [1:0]             ALUSrcB_out;
  logic [1:0]             pcSource_out;
  logic [ALU_CNTRL_W-1:0] ALUCntrl_out;
  logic [2:0]             state_out;
  logic                   illegal_out;
  logic                   timeout_out;
  logic [CNT_W-1:0]       retired_out;

  modport master (
    input  op_in, func_in, zero_in, mem_ready_in,
    output pcWrite_out, irWrite_out, memRead_out, memWrite_out, iOrD_out,
           regWrite_out, regDst_out, memToReg_out, ALUSrcA_out, extCntrl_out,
           ALUSrcB_out, pcSource_out, ALUCntrl_out, state_out,
           illegal_out, timeout_out, retired_out
  );

  modport slave (
    output op_in, func_in, zero_in, mem_ready_in,
    input  pcWrite_out, irWrite_out, memRead_out, memWrite_out, iOrD_out,
           regWrite_out, regDst_out, memToReg_out, ALUSrcA_out, extCntrl_out,
           ALUSrcB_out, pcSource_out, ALUCntrl_out, state_out,
           illegal_out, timeout_out, retired_out
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM with memory timeout and retire counter
module mips_multicycle_control #(
  parameter int ALU_CNTRL_W = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  mips_multicycle_control_if.master  bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_LUI = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       ext_cntrl;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_cntrl;
  } ctrl_t;

  function automatic logic is_rtype(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_R) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27});
  endfunction

  function automatic logic is_iarith(input logic [5:0] op);
    return op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LUI};
  endfunction

  function automatic logic [3:0] alu_code(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] code;
    code = ALU_AND;
    case (op)
      OP_R: begin
        case (fn)
          6'h20:   code = ALU_ADD;
          6'h22:   code = ALU_SUB;
          6'h24:   code = ALU_AND;
          6'h25:   code = ALU_OR;
          6'h2a:   code = ALU_SLT;
          6'h27:   code = ALU_NOR;
          default: code = ALU_AND;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: code = ALU_ADD;
      OP_ANDI:               code = ALU_AND;
      OP_ORI:                code = ALU_OR;
      OP_LUI:                code = ALU_LUI;
      OP_BEQ, OP_BNE:        code = ALU_SUB;
      default:               code = ALU_AND;
    endcase
    return code;
  endfunction

  // Moore part of the outputs; the ready/zero qualified strobes are added at the ports.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_cntrl = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.ext_cntrl = 1'b1;
        c.alu_cntrl = ALU_ADD;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = (op == OP_R) ? 2'b00 : 2'b10;
        c.alu_cntrl = alu_code(op, fn);
        c.ext_cntrl = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
      end
      S_MEM: begin
        c.i_or_d    = 1'b1;
        c.mem_read  = (op == OP_LW);
        c.mem_write = (op == OP_SW);
      end
      S_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = (op == OP_R);
        c.mem_to_reg = (op == OP_LW);
        c.alu_cntrl  = alu_code(op, fn);
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_cntrl = ALU_SUB;
        c.pc_source = 2'b01;
      end
      S_JUMP: begin
        c.pc_source = 2'b10;
        c.pc_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t            r_state;
  logic [5:0]        r_op;
  logic [5:0]        r_func;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_retired;
  logic              r_illegal;
  logic              r_timeout;
  ctrl_t             r_ctrl;

  state_t            w_next_state;
  logic [5:0]        w_next_op;
  logic [5:0]        w_next_func;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_wait_expired;
  logic              w_set_illegal;
  logic              w_set_timeout;
  logic              w_pc_qual;

  assign w_wait_inc     = r_wait + 1'b1;
  // A ready in the expiring cycle still wins over the timeout.
  assign w_wait_expired = !bus.mem_ready_in && (w_wait_inc == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    w_next_state  = r_state;
    w_next_op     = r_op;
    w_next_func   = r_func;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready_in) begin
          w_next_state = S_DECODE;
        end else if (w_wait_expired) begin
          w_next_state  = S_HALT;
          w_set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        w_next_op   = bus.op_in;
        w_next_func = bus.func_in;
        if (is_rtype(bus.op_in, bus.func_in) || is_iarith(bus.op_in) ||
            bus.op_in == OP_LW || bus.op_in == OP_SW) begin
          w_next_state = S_EXEC;
        end else if (bus.op_in == OP_BEQ || bus.op_in == OP_BNE) begin
          w_next_state = S_BRANCH;
        end else if (bus.op_in == OP_J) begin
          w_next_state = S_JUMP;
        end else if (bus.op_in == OP_R && bus.func_in == 6'h00) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state  = S_HALT;
          w_set_illegal = 1'b1;
        end
      end
      S_EXEC: w_next_state = (r_op == OP_LW || r_op == OP_SW) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.mem_ready_in) begin
          w_next_state = (r_op == OP_LW) ? S_WB : S_FETCH;
        end else if (w_wait_expired) begin
          w_next_state  = S_HALT;
          w_set_timeout = 1'b1;
        end
      end
      S_WB, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
      default: w_next_state = S_HALT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state   <= S_FETCH;
      r_op      <= '0;
      r_func    <= '0;
      r_wait    <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_ctrl    <= decode(S_FETCH, 6'h00, 6'h00);
    end else begin
      r_state <= w_next_state;
      r_op    <= w_next_op;
      r_func  <= w_next_func;
      r_ctrl  <= decode(w_next_state, w_next_op, w_next_func);
      if (w_next_state != r_state && (w_next_state == S_FETCH || w_next_state == S_MEM)) begin
        r_wait <= '0;
      end else if ((r_state == S_FETCH || r_state == S_MEM) && !bus.mem_ready_in) begin
        r_wait <= w_wait_inc;
      end
      // Every path back into FETCH from another state completes an instruction.
      if (w_next_state == S_FETCH && r_state != S_FETCH) begin
        r_retired <= r_retired + 1'b1;
      end
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_set_timeout) r_timeout <= 1'b1;
    end
  end

  assign w_pc_qual = ((r_state == S_FETCH) && bus.mem_ready_in) ||
                     ((r_state == S_BRANCH) &&
                      (((r_op == OP_BEQ) && bus.zero_in) || ((r_op == OP_BNE) && !bus.zero_in)));

  assign bus.pcWrite_out  = rst_n_in && (r_ctrl.pc_write || w_pc_qual);
  assign bus.irWrite_out  = rst_n_in && (r_state == S_FETCH) && bus.mem_ready_in;
  assign bus.memRead_out  = rst_n_in && r_ctrl.mem_read;
  assign bus.memWrite_out = rst_n_in && r_ctrl.mem_write;
  assign bus.regWrite_out = rst_n_in && r_ctrl.reg_write;
  assign bus.iOrD_out     = r_ctrl.i_or_d;
  assign bus.regDst_out   = r_ctrl.reg_dst;
  assign bus.memToReg_out = r_ctrl.mem_to_reg;
  assign bus.ALUSrcA_out  = r_ctrl.alu_src_a;
  assign bus.extCntrl_out = r_ctrl.ext_cntrl;
  assign bus.ALUSrcB_out  = r_ctrl.alu_src_b;
  assign bus.pcSource_out = r_ctrl.pc_source;
  assign bus.ALUCntrl_out = ALU_CNTRL_W'(r_ctrl.alu_cntrl);
  assign bus.state_out    = r_state;
  assign bus.illegal_out  = r_illegal;
  assign bus.timeout_out  = r_timeout;
  assign bus.retired_out  = r_retired;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - scoreboard bench for the multicycle MIPS controller
module tb_mips_multicycle_control;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_multicycle_control_if #(.ALU_CNTRL_W(4), .CNT_W(CNT_W)) bus();

  mips_multicycle_control #(.ALU_CNTRL_W(4), .CNT_W(CNT_W), .MEM_TIMEOUT(15)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  typedef enum int {
    F_STATE, F_PCW, F_IRW, F_MRD, F_MWR, F_IORD, F_RW, F_RDST, F_M2R,
    F_SRCA, F_EXT, F_SRCB, F_PCSRC, F_ALU, F_ILL, F_TMO, F_RET, F_STROBES
  } field_t;

  typedef struct {
    int     cyc;
    field_t f;
    int     exp;
    string  name;
  } chk_t;

  chk_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int observe(input field_t f);
    case (f)
      F_STATE:   return int'(bus.state_out);
      F_PCW:     return int'(bus.pcWrite_out);
      F_IRW:     return int'(bus.irWrite_out);
      F_MRD:     return int'(bus.memRead_out);
      F_MWR:     return int'(bus.memWrite_out);
      F_IORD:    return int'(bus.iOrD_out);
      F_RW:      return int'(bus.regWrite_out);
      F_RDST:    return int'(bus.regDst_out);
      F_M2R:     return int'(bus.memToReg_out);
      F_SRCA:    return int'(bus.ALUSrcA_out);
      F_EXT:     return int'(bus.extCntrl_out);
      F_SRCB:    return int'(bus.ALUSrcB_out);
      F_PCSRC:   return int'(bus.pcSource_out);
      F_ALU:     return int'(bus.ALUCntrl_out);
      F_ILL:     return int'(bus.illegal_out);
      F_TMO:     return int'(bus.timeout_out);
      F_RET:     return int'(bus.retired_out);
      F_STROBES: return int'({bus.pcWrite_out, bus.irWrite_out, bus.memRead_out,
                              bus.memWrite_out, bus.regWrite_out});
      default:   return -1;
    endcase
  endfunction

  // Monitor: outputs are presented every cycle; pop and compare everything queued for it.
  always @(negedge clk) begin
    chk_t c;
    int   act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      c   = sb.pop_front();
      act = observe(c.f);
      n_checks++;
      if (c.cyc == cyc && act == c.exp) n_pass++;
      else $display("FAIL %s (cycle %0d, seen %0d): got %0d expected %0d", c.name, c.cyc, cyc, act, c.exp);
    end
  end

  task automatic step(input logic rn, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy);
    @(posedge clk);
    #1;
    rst_n            = rn;
    bus.op_in        = op;
    bus.func_in      = fn;
    bus.zero_in      = z;
    bus.mem_ready_in = rdy;
  endtask

  task automatic want(input field_t f, input int v, input string nm);
    sb.push_back('{cyc, f, v, nm});
  endtask

  task automatic fetch_ok(input logic [5:0] op, input logic [5:0] fn, input logic z, input int ret);
    step(1'b1, op, fn, z, 1'b1);
    want(F_STATE, 0, "fetch_state");
    want(F_IRW, 1, "fetch_irwrite");
    want(F_PCW, 1, "fetch_pcwrite");
    want(F_MRD, 1, "fetch_memread");
    want(F_SRCB, 1, "fetch_alusrcb");
    want(F_ALU, 2, "fetch_alu");
    want(F_RET, ret, "retired");
  endtask

  task automatic decode_ok(input logic [5:0] op, input logic [5:0] fn, input logic z);
    step(1'b1, op, fn, z, 1'b1);
    want(F_STATE, 1, "decode_state");
    want(F_SRCB, 3, "decode_alusrcb");
    want(F_EXT, 1, "decode_ext");
    want(F_ALU, 2, "decode_alu");
  endtask

  int nop_ret[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0;
    bus.op_in = '0; bus.func_in = '0; bus.zero_in = 1'b0; bus.mem_ready_in = 1'b0;

    // Reset: strobes forced low even with ready high in FETCH.
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
    want(F_STROBES, 0, "reset_strobes");
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
    want(F_STROBES, 0, "reset_strobes_ready");
    want(F_STATE, 0, "reset_state");
    want(F_RET, 0, "reset_retired");
    want(F_ILL, 0, "reset_illegal");
    want(F_TMO, 0, "reset_timeout");

    // Five nops with a 2-bit counter: 1,2,3,0,1.
    for (int i = 0; i < 5; i++) begin
      fetch_ok(6'h00, 6'h00, 1'b0, nop_ret[i]);
      decode_ok(6'h00, 6'h00, 1'b0);
    end

    // add
    fetch_ok(6'h00, 6'h20, 1'b0, 1);
    decode_ok(6'h00, 6'h20, 1'b0);
    step(1'b1, 6'h00, 6'h20, 1'b0, 1'b1);
    want(F_STATE, 2, "add_exec_state"); want(F_SRCA, 1, "add_srca");
    want(F_SRCB, 0, "add_srcb"); want(F_ALU, 2, "add_exec_alu");
    step(1'b1, 6'h00, 6'h20, 1'b0, 1'b1);
    want(F_STATE, 4, "add_wb_state"); want(F_RW, 1, "add_regwrite");
    want(F_RDST, 1, "add_regdst"); want(F_ALU, 2, "add_wb_alu"); want(F_M2R, 0, "add_memtoreg");

    // lw with two wait cycles
    fetch_ok(6'h23, 6'h00, 1'b0, 2);
    decode_ok(6'h23, 6'h00, 1'b0);
    step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1);
    want(F_STATE, 2, "lw_exec_state"); want(F_SRCB, 2, "lw_srcb");
    want(F_EXT, 1, "lw_ext"); want(F_ALU, 2, "lw_alu");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6'h23, 6'h00, 1'b0, (i == 2));
      want(F_STATE, 3, "lw_mem_state"); want(F_MRD, 1, "lw_memread");
      want(F_IORD, 1, "lw_iord"); want(F_MWR, 0, "lw_memwrite");
    end
    step(1'b1, 6'h23, 6'h00, 1'b0, 1'b1);
    want(F_STATE, 4, "lw_wb_state"); want(F_M2R, 1, "lw_memtoreg");
    want(F_RDST, 0, "lw_regdst"); want(F_RW, 1, "lw_regwrite");

    // beq not taken, then bne taken
    fetch_ok(6'h04, 6'h00, 1'b0, 3);
    decode_ok(6'h04, 6'h00, 1'b0);
    step(1'b1, 6'h04, 6'h00, 1'b0, 1'b1);
    want(F_STATE, 5, "beq_state"); want(F_PCW, 0, "beq_pcwrite");
    want(F_PCSRC, 1, "beq_pcsource"); want(F_ALU, 6, "beq_alu");
    fetch_ok(6'h05, 6'h00, 1'b0, 0);
    decode_ok(6'h05, 6'h00, 1'b0);
    step(1'b1, 6'h05, 6'h00, 1'b0, 1'b1);
    want(F_STATE, 5, "bne_state"); want(F_PCW, 1, "bne_pcwrite"); want(F_PCSRC, 1, "bne_pcsource");

    // sw
    fetch_ok(6'h2b, 6'h00, 1'b0, 1);
    decode_ok(6'h2b, 6'h00, 1'b0);
    step(1'b1, 6'h2b, 6'h00, 1'b0, 1'b1);
    want(F_STATE, 2, "sw_exec_state"); want(F_SRCB, 2, "sw_srcb"); want(F_EXT, 1, "sw_ext");
    step(1'b1, 6'h2b, 6'h00, 1'b0, 1'b1);
    want(F_STATE, 3, "sw_mem_state"); want(F_MWR, 1, "sw_memwrite");
    want(F_MRD, 0, "sw_memread"); want(F_IORD, 1, "sw_iord");

    // j
    fetch_ok(6'h02, 6'h00, 1'b0, 2);
    decode_ok(6'h02, 6'h00, 1'b0);
    step(1'b1, 6'h02, 6'h00, 1'b0, 1'b1);
    want(F_STATE, 6, "j_state"); want(F_PCW, 1, "j_pcwrite"); want(F_PCSRC, 2, "j_pcsource");

    // andi zero-extends and uses the and code
    fetch_ok(6'h0c, 6'h00, 1'b0, 3);
    decode_ok(6'h0c, 6'h00, 1'b0);
    step(1'b1, 6'h0c, 6'h00, 1'b0, 1'b1);
    want(F_STATE, 2, "andi_exec_state"); want(F_EXT, 0, "andi_ext");
    want(F_ALU, 0, "andi_alu"); want(F_SRCB, 2, "andi_srcb");
    step(1'b1, 6'h0c, 6'h00, 1'b0, 1'b1);
    want(F_STATE, 4, "andi_wb_state"); want(F_RDST, 0, "andi_regdst");

    // Illegal opcode halts until reset
    fetch_ok(6'h3f, 6'h00, 1'b0, 0);
    decode_ok(6'h3f, 6'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 6'h3f, 6'h00, 1'b0, 1'b1);
      want(F_STATE, 7, "illegal_halt_state"); want(F_ILL, 1, "illegal_flag");
      want(F_STROBES, 0, "halt_strobes");
    end
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
    want(F_STROBES, 0, "halt_reset_strobes");

    // FETCH starved of ready: 15 waiting cycles, then HALT with timeout
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 6'h00, 6'h00, 1'b0, 1'b0);
      want(F_STATE, 0, "starve_state"); want(F_IRW, 0, "starve_irwrite");
      if (i == 1) begin
        want(F_ILL, 0, "post_reset_illegal"); want(F_RET, 0, "post_reset_retired");
        want(F_TMO, 0, "post_reset_timeout");
      end
    end
    step(1'b1, 6'h00, 6'h00, 1'b0, 1'b0);
    want(F_STATE, 7, "timeout_state"); want(F_TMO, 1, "timeout_flag"); want(F_STROBES, 0, "timeout_strobes");
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);

    // Ready arriving in the 15th waiting cycle is a success
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 6'h00, 6'h00, 1'b0, (i == 15));
      want(F_STATE, 0, "late_ready_fetch_state");
      if (i == 15) want(F_IRW, 1, "late_ready_irwrite");
    end
    step(1'b1, 6'h00, 6'h00, 1'b0, 1'b1);
    want(F_STATE, 1, "late_ready_decode"); want(F_TMO, 0, "late_ready_no_timeout");

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
